// File: rtl/st7735_pkg.sv
`default_nettype none
// ============================================================================
// st7735_pkg : ST7735 opcode constants and receiver command-FSM states
// Rev 1.0
// ============================================================================
package st7735_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CASET  = 3'd1,
    RASET  = 3'd2,
    RAMWR  = 3'd3,
    IGNORE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/st7735_spi_byte_rx.sv
`default_nettype none
// ============================================================================
// st7735_spi_byte_rx : oversampled SPI mode-0 byte deserialiser with ss framing
// Rev 1.0
// ============================================================================
module st7735_spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_spi_clk,
  input  logic       i_spi_mosi,
  input  logic       i_spi_d_c,
  input  logic       i_spi_ss,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_is_data,
  output logic       o_ss_high
);

  logic [SYNC_STAGES-1:0] r_clk_s, r_mosi_s, r_dc_s, r_ss_s;
  logic                   r_clk_prev;
  logic [2:0]             r_cnt;
  logic [6:0]             r_shift;
  logic                   w_clk, w_mosi, w_ss, w_rise;

  assign w_clk  = r_clk_s[SYNC_STAGES-1];
  assign w_mosi = r_mosi_s[SYNC_STAGES-1];
  assign w_ss   = r_ss_s[SYNC_STAGES-1];
  assign w_rise = w_clk & ~r_clk_prev & ~w_ss & i_enable;

  // ss synchronizer resets to deselected so no edge is seen before a real select
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clk_s    <= '0;
      r_mosi_s   <= '0;
      r_dc_s     <= '0;
      r_ss_s     <= '1;
      r_clk_prev <= 1'b0;
      r_cnt      <= 3'd0;
      r_shift    <= 7'd0;
    end else begin
      r_clk_s    <= {r_clk_s[SYNC_STAGES-2:0], i_spi_clk};
      r_mosi_s   <= {r_mosi_s[SYNC_STAGES-2:0], i_spi_mosi};
      r_dc_s     <= {r_dc_s[SYNC_STAGES-2:0], i_spi_d_c};
      r_ss_s     <= {r_ss_s[SYNC_STAGES-2:0], i_spi_ss};
      r_clk_prev <= w_clk;
      if (w_ss) begin
        r_cnt <= 3'd0;
      end else if (w_rise) begin
        r_cnt   <= r_cnt + 3'd1;
        r_shift <= {r_shift[5:0], w_mosi};
      end
    end
  end

  assign o_byte_valid = w_rise & (r_cnt == 3'd7);
  assign o_byte       = {r_shift, w_mosi};
  assign o_is_data    = r_dc_s[SYNC_STAGES-1];
  assign o_ss_high    = w_ss;

endmodule
`default_nettype wire

// File: rtl/st7735_spi_receiver.sv
`default_nettype none
// ============================================================================
// st7735_spi_receiver : ST7735 panel-side command decoder and pixel writer
// Rev 1.0
// ============================================================================
module st7735_spi_receiver
  import st7735_pkg::*;
#(
  parameter int SCREEN_SIZE = 128,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk_main,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  input  logic              i_spi_d_c,
  input  logic              i_spi_ss,
  output logic              o_spi_miso,
  output logic [ADDR_W-1:0] o_pixel_addr_x,
  output logic [ADDR_W-1:0] o_pixel_addr_y,
  output logic [15:0]       o_pixel_wr_data,
  output logic              o_pixel_wr_en,
  output logic              o_cmd_valid,
  output logic [7:0]        o_cmd_byte,
  output logic              o_frame_done
);

  localparam logic [15:0]       c_MAX16 = 16'(SCREEN_SIZE - 1);
  localparam logic [ADDR_W-1:0] c_MAXA  = ADDR_W'(SCREEN_SIZE - 1);

  function automatic logic [ADDR_W-1:0] clamp(input logic [15:0] v);
    clamp = (v > c_MAX16) ? c_MAXA : v[ADDR_W-1:0];
  endfunction

  logic       w_bv, w_is_data, w_ss_high;
  logic [7:0] w_byte;

  st7735_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .i_clk       (i_clk_main),
    .i_rst_n     (i_rst_n),
    .i_enable    (i_enable),
    .i_spi_clk   (i_spi_clk),
    .i_spi_mosi  (i_spi_mosi),
    .i_spi_d_c   (i_spi_d_c),
    .i_spi_ss    (i_spi_ss),
    .o_byte_valid(w_bv),
    .o_byte      (w_byte),
    .o_is_data   (w_is_data),
    .o_ss_high   (w_ss_high)
  );

  state_t            r_state, w_state;
  logic [2:0]        r_idx, w_idx;
  logic [15:0]       r_start, w_start;
  logic [7:0]        r_end_hi, w_end_hi, r_hi, w_hi, r_cmd, w_cmd;
  logic [ADDR_W-1:0] r_xs, r_xe, r_ys, r_ye, r_px, r_py;
  logic [ADDR_W-1:0] w_xs, w_xe, w_ys, w_ye, w_px, w_py;
  logic [ADDR_W-1:0] r_ax, r_ay, w_ax, w_ay, w_s, w_e;
  logic [15:0]       r_data, w_data;
  logic              r_half, w_half, r_pen, w_pen, r_cv, w_cv, r_fd, w_fd;

  always_ff @(posedge i_clk_main) begin
    if (!i_rst_n) begin
      r_state <= IDLE;   r_idx <= 3'd0;  r_start <= 16'd0;  r_end_hi <= 8'd0;
      r_hi    <= 8'd0;   r_cmd <= 8'd0;  r_half  <= 1'b0;
      r_xs    <= '0;     r_xe  <= c_MAXA; r_ys   <= '0;     r_ye <= c_MAXA;
      r_px    <= '0;     r_py  <= '0;    r_ax    <= '0;     r_ay <= '0;
      r_data  <= 16'd0;  r_pen <= 1'b0;  r_cv    <= 1'b0;   r_fd <= 1'b0;
    end else begin
      r_state <= w_state; r_idx <= w_idx; r_start <= w_start; r_end_hi <= w_end_hi;
      r_hi    <= w_hi;    r_cmd <= w_cmd; r_half  <= w_half;
      r_xs    <= w_xs;    r_xe  <= w_xe;  r_ys    <= w_ys;    r_ye <= w_ye;
      r_px    <= w_px;    r_py  <= w_py;  r_ax    <= w_ax;    r_ay <= w_ay;
      r_data  <= w_data;  r_pen <= w_pen; r_cv    <= w_cv;    r_fd <= w_fd;
    end
  end

  always_comb begin
    w_state = r_state; w_idx = r_idx; w_start = r_start; w_end_hi = r_end_hi;
    w_hi    = r_hi;    w_cmd = r_cmd; w_half  = r_half;
    w_xs    = r_xs;    w_xe  = r_xe;  w_ys    = r_ys;    w_ye = r_ye;
    w_px    = r_px;    w_py  = r_py;  w_ax    = r_ax;    w_ay = r_ay;
    w_data  = r_data;  w_pen = 1'b0;  w_cv    = 1'b0;    w_fd = 1'b0;
    w_s     = clamp(r_start);
    w_e     = clamp({r_end_hi, w_byte});
    if (w_s > w_e) w_e = w_s;
    if (w_ss_high) w_half = 1'b0;

    if (w_bv && !w_is_data) begin
      w_cv   = 1'b1;
      w_cmd  = w_byte;
      w_half = 1'b0;
      w_idx  = 3'd0;
      case (w_byte)
        CMD_CASET: w_state = CASET;
        CMD_RASET: w_state = RASET;
        CMD_RAMWR: begin
          w_state = RAMWR;
          w_px    = r_xs;
          w_py    = r_ys;
        end
        CMD_SWRESET: begin
          w_state = IDLE;
          w_xs = '0; w_xe = c_MAXA; w_ys = '0; w_ye = c_MAXA;
        end
        default: w_state = IGNORE;
      endcase
    end else if (w_bv) begin
      case (r_state)
        CASET, RASET: begin
          // index saturates at 4 so bytes past end_lo are dropped
          if (r_idx != 3'd4) w_idx = r_idx + 3'd1;
          case (r_idx)
            3'd0: w_start[15:8] = w_byte;
            3'd1: w_start[7:0]  = w_byte;
            3'd2: w_end_hi      = w_byte;
            3'd3: begin
              if (r_state == CASET) begin
                w_xs = w_s; w_xe = w_e;
              end else begin
                w_ys = w_s; w_ye = w_e;
              end
            end
            default: ;
          endcase
        end
        RAMWR: begin
          if (!r_half) begin
            w_hi   = w_byte;
            w_half = 1'b1;
          end else begin
            w_half = 1'b0;
            w_pen  = 1'b1;
            w_data = {r_hi, w_byte};
            w_ax   = r_px;
            w_ay   = r_py;
            if (r_px == r_xe) begin
              w_px = r_xs;
              if (r_py == r_ye) begin
                w_py = r_ys;
                w_fd = 1'b1;
              end else begin
                w_py = r_py + 1'b1;
              end
            end else begin
              w_px = r_px + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_spi_miso      = 1'b0;
  assign o_pixel_addr_x  = r_ax;
  assign o_pixel_addr_y  = r_ay;
  assign o_pixel_wr_data = r_data;
  assign o_pixel_wr_en   = r_pen;
  assign o_cmd_valid     = r_cv;
  assign o_cmd_byte      = r_cmd;
  assign o_frame_done    = r_fd;

endmodule
`default_nettype wire
